// File: rtl/mopshub_cs_sequencer.sv
// mopshub_cs_sequencer: round-robin / single-bus chip-select sequencer with SPI start/done handshake
module mopshub_cs_sequencer #(
  parameter int N_BUS = 16,
  parameter int SEL_W = 5,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BUS-1:0] bus_en,
  input  logic             scan_start,
  input  logic             single_req,
  input  logic [SEL_W-1:0] single_sel,
  input  logic             spi_done,
  output logic             spi_start,
  output logic [N_BUS-1:0] cs_n,
  output logic [SEL_W-1:0] bus_cnt,
  output logic             busy,
  output logic             scan_done,
  output logic             timeout_err,
  output logic [SEL_W-1:0] err_bus
);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, START = 3'd2, WAIT = 3'd3, HOLD = 3'd4;
  localparam int MAX_SH = SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_C = TIMEOUT_CYC > MAX_SH ? TIMEOUT_CYC : MAX_SH;
  localparam int CNT_W = $clog2(MAX_C) > 0 ? $clog2(MAX_C) : 1;
  logic [2:0] state;
  logic [CNT_W-1:0] cnt;
  logic [N_BUS-1:0] mask, upper;
  logic single;
  function automatic logic [SEL_W-1:0] lowest(input logic [N_BUS-1:0] m);
    lowest = '0;
    for (int i = N_BUS - 1; i >= 0; i--) if (m[i]) lowest = SEL_W'(i);
  endfunction
  function automatic logic [N_BUS-1:0] sel_cs(input logic [SEL_W-1:0] b);
    return ~(N_BUS'(1) << b);
  endfunction
  // latched mask with bits at and below the current bus cleared; no wrap-around
  assign upper = mask & ~((N_BUS'(2) << bus_cnt) - N_BUS'(1));
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mask <= '0;
      single <= 1'b0;
      cs_n <= '1;
      bus_cnt <= '0;
      err_bus <= '0;
      spi_start <= 1'b0;
      scan_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      scan_done <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (single_req) begin
            if (int'(single_sel) >= N_BUS) begin
              timeout_err <= 1'b1;
              err_bus <= single_sel;
            end else begin
              single <= 1'b1;
              bus_cnt <= single_sel;
              cs_n <= sel_cs(single_sel);
              state <= SETUP;
            end
          end else if (scan_start) begin
            single <= 1'b0;
            mask <= bus_en;
            if (bus_en == '0) scan_done <= 1'b1;
            else begin
              bus_cnt <= lowest(bus_en);
              cs_n <= sel_cs(lowest(bus_en));
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(SETUP_CYC - 1)) begin
            spi_start <= 1'b1;
            state <= START;
          end
        end
        START: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (spi_done || cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= !spi_done;
            if (!spi_done) err_bus <= bus_cnt;
            cs_n <= '1;
            cnt <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(HOLD_CYC - 1)) begin
            cnt <= '0;
            if (!single && upper != '0) begin
              bus_cnt <= lowest(upper);
              cs_n <= sel_cs(lowest(upper));
              state <= SETUP;
            end else begin
              scan_done <= !single;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
